// File: rtl/uart_tx_write_arbiter.sv
// Write-port arbiter for the UART TX FIFO.
//
// Two byte-stream requesters share the single FIFO write port. Ownership is
// granted for a whole frame so frames never interleave, and ties are broken
// round-robin. A requester is released early, with a one-cycle error pulse,
// if its frame runs past MAX_FRAME bytes or if it idles for IDLE_TIMEOUT
// owned cycles.
//
// Ports:
//   clock, reset                 clock and async active-low reset
//   req0/valid0/data0/last0      requester 0 frame request and byte stream
//   ready0                       requester 0 byte accepted this cycle
//   req1/valid1/data1/last1      requester 1 frame request and byte stream
//   ready1                       requester 1 byte accepted this cycle
//   fifo_full                    TX FIFO full flag
//   fifo_write_flag              FIFO write strobe
//   fifo_data_in                 byte to the FIFO
//   grant                        one-hot owner, 00 when idle
//   busy                         frame in progress
//   error                        one-cycle pulse on forced release
//   error_src                    requester behind the last error (sticky)
module uart_tx_write_arbiter #(
    parameter int unsigned MAX_FRAME    = 64,
    parameter int unsigned IDLE_TIMEOUT = 255,
    parameter int unsigned CNT_BITS     = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic       valid0,
    input  logic [7:0] data0,
    input  logic       last0,
    output logic       ready0,
    input  logic       req1,
    input  logic       valid1,
    input  logic [7:0] data1,
    input  logic       last1,
    output logic       ready1,
    input  logic       fifo_full,
    output logic       fifo_write_flag,
    output logic [7:0] fifo_data_in,
    output logic [1:0] grant,
    output logic       busy,
    output logic       error,
    output logic       error_src
);

    // State encoding doubles as the one-hot grant vector.
    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StOwn0 = 2'b01;
    localparam logic [1:0] StOwn1 = 2'b10;

    localparam logic [CNT_BITS-1:0] MaxFrameC    = CNT_BITS'(MAX_FRAME);
    localparam logic [CNT_BITS-1:0] IdleTimeoutC = CNT_BITS'(IDLE_TIMEOUT);
    localparam logic [CNT_BITS-1:0] OneC         = CNT_BITS'(1);

    logic [1:0]          state_q, state_d;
    logic [CNT_BITS-1:0] byte_cnt_q, byte_cnt_d;
    logic [CNT_BITS-1:0] idle_cnt_q, idle_cnt_d;
    logic                last_winner_q, last_winner_d;
    logic                error_q, error_d;
    logic                error_src_q, error_src_d;

    logic                own0, own1, owned;
    logic                sel_valid, sel_last;
    logic [7:0]          sel_data;
    logic                accept;
    logic [CNT_BITS-1:0] byte_inc, idle_inc;
    logic                release_now, forced;

    // Datapath mux and accept rule
    always_comb begin
        own0      = (state_q == StOwn0);
        own1      = (state_q == StOwn1);
        owned     = own0 | own1;
        sel_valid = own1 ? valid1 : valid0;
        sel_last  = own1 ? last1  : last0;
        sel_data  = own1 ? data1  : data0;
        accept    = owned & sel_valid & ~fifo_full;

        ready0          = own0 & ~fifo_full;
        ready1          = own1 & ~fifo_full;
        fifo_write_flag = accept;
        fifo_data_in    = owned ? sel_data : 8'h00;
        grant           = state_q;
        busy            = owned;
        error           = error_q;
        error_src       = error_src_q;
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        last_winner_d = last_winner_q;
        error_d       = 1'b0;
        error_src_d   = error_src_q;
        byte_inc      = byte_cnt_q + OneC;
        idle_inc      = idle_cnt_q + OneC;
        release_now   = 1'b0;
        forced        = 1'b0;

        case (state_q)
            StIdle: begin
                // On a tie the requester that did not win last time goes first.
                if (req0 && (!req1 || last_winner_q)) begin
                    state_d = StOwn0;
                end else if (req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                if (accept) begin
                    byte_cnt_d = byte_inc;
                    idle_cnt_d = '0;
                    if (sel_last) begin
                        release_now = 1'b1;
                    end else if (byte_inc == MaxFrameC) begin
                        release_now = 1'b1;
                        forced      = 1'b1;
                    end
                end else begin
                    // Stalls on a full FIFO count as idle too, so a FIFO that
                    // never drains still ends the frame.
                    idle_cnt_d = idle_inc;
                    if (idle_inc == IdleTimeoutC) begin
                        release_now = 1'b1;
                        forced      = 1'b1;
                    end
                end

                if (release_now) begin
                    state_d       = StIdle;
                    last_winner_d = own1;
                    byte_cnt_d    = '0;
                    idle_cnt_d    = '0;
                end
                if (forced) begin
                    error_d     = 1'b1;
                    error_src_d = own1;
                end
            end
            default: begin
                state_d    = StIdle;
                byte_cnt_d = '0;
                idle_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            byte_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            last_winner_q <= 1'b1;
            error_q       <= 1'b0;
            error_src_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            last_winner_q <= last_winner_d;
            error_q       <= error_d;
            error_src_q   <= error_src_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_write_arbiter.sv
// Directed bench for uart_tx_write_arbiter (MAX_FRAME=4, IDLE_TIMEOUT=6).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_uart_tx_write_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, valid0 = 1'b0, last0 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic       req1 = 1'b0, valid1 = 1'b0, last1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       fifo_full = 1'b0;
    logic       ready0, ready1, fifo_write_flag, busy, error, error_src;
    logic [7:0] fifo_data_in;
    logic [1:0] grant;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_write_arbiter #(
        .MAX_FRAME    (4),
        .IDLE_TIMEOUT (6),
        .CNT_BITS     (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req0            (req0),
        .valid0          (valid0),
        .data0           (data0),
        .last0           (last0),
        .ready0          (ready0),
        .req1            (req1),
        .valid1          (valid1),
        .data1           (data1),
        .last1           (last1),
        .ready1          (ready1),
        .fifo_full       (fifo_full),
        .fifo_write_flag (fifo_write_flag),
        .fifo_data_in    (fifo_data_in),
        .grant           (grant),
        .busy            (busy),
        .error           (error),
        .error_src       (error_src)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write strobe, data (when writing), grant and error in one go.
    task automatic expect_out(input string tag, input logic wr, input logic [7:0] d,
                              input logic [1:0] g, input logic err);
        check({tag, ".wr"}, 32'(fifo_write_flag), 32'(wr));
        if (wr) check({tag, ".data"}, 32'(fifo_data_in), 32'(d));
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".error"}, 32'(error), 32'(err));
    endtask

    task automatic drv0(input logic r, input logic v, input logic [7:0] d, input logic l);
        req0 = r; valid0 = v; data0 = d; last0 = l;
    endtask

    task automatic drv1(input logic r, input logic v, input logic [7:0] d, input logic l);
        req1 = r; valid1 = v; data1 = d; last1 = l;
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        // Reset values
        step();
        settle();
        expect_out("rst", 1'b0, 8'h00, 2'b00, 1'b0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.error_src", 32'(error_src), 32'd0);
        check("rst.ready0", 32'(ready0), 32'd0);
        step();
        reset = 1'b1;

        // Single frame A1,A2,A3 from requester 0
        step(); drv0(1, 1, 8'hA1, 0); settle();
        expect_out("single.idle", 1'b0, 8'h00, 2'b00, 1'b0);
        check("single.idle.ready0", 32'(ready0), 32'd0);
        step(); settle();
        expect_out("single.b1", 1'b1, 8'hA1, 2'b01, 1'b0);
        check("single.b1.ready0", 32'(ready0), 32'd1);
        check("single.b1.busy", 32'(busy), 32'd1);
        step(); drv0(1, 1, 8'hA2, 0); settle();
        expect_out("single.b2", 1'b1, 8'hA2, 2'b01, 1'b0);
        step(); drv0(1, 1, 8'hA3, 1); settle();
        expect_out("single.b3", 1'b1, 8'hA3, 2'b01, 1'b0);
        step(); drv0(0, 0, 8'h00, 0); settle();
        expect_out("single.done", 1'b0, 8'h00, 2'b00, 1'b0);
        check("single.done.busy", 32'(busy), 32'd0);

        // Contention from reset: 0, bubble, 1, bubble, 0
        do_reset();
        drv0(1, 1, 8'hB1, 0); drv1(1, 1, 8'hC1, 0); settle();
        expect_out("cont.idle", 1'b0, 8'h00, 2'b00, 1'b0);
        step(); settle();
        expect_out("cont.r0b1", 1'b1, 8'hB1, 2'b01, 1'b0);
        check("cont.r0b1.ready1", 32'(ready1), 32'd0);
        step(); drv0(1, 1, 8'hB2, 1); settle();
        expect_out("cont.r0b2", 1'b1, 8'hB2, 2'b01, 1'b0);
        step(); drv0(1, 1, 8'hB3, 0); settle();
        expect_out("cont.bubble1", 1'b0, 8'h00, 2'b00, 1'b0);
        step(); settle();
        expect_out("cont.r1b1", 1'b1, 8'hC1, 2'b10, 1'b0);
        check("cont.r1b1.ready0", 32'(ready0), 32'd0);
        check("cont.r1b1.ready1", 32'(ready1), 32'd1);
        step(); drv1(1, 1, 8'hC2, 1); settle();
        expect_out("cont.r1b2", 1'b1, 8'hC2, 2'b10, 1'b0);
        step(); settle();
        expect_out("cont.bubble2", 1'b0, 8'h00, 2'b00, 1'b0);
        step(); drv0(1, 1, 8'hB3, 1); settle();
        expect_out("cont.r0again", 1'b1, 8'hB3, 2'b01, 1'b0);
        step(); drv0(0, 0, 8'h00, 0); drv1(0, 0, 8'h00, 0); settle();
        expect_out("cont.done", 1'b0, 8'h00, 2'b00, 1'b0);

        // Backpressure: full for 5 cycles after byte 2
        step(); drv0(1, 1, 8'hD1, 0);
        step(); settle();
        expect_out("bp.b1", 1'b1, 8'hD1, 2'b01, 1'b0);
        step(); drv0(1, 1, 8'hD2, 0); settle();
        expect_out("bp.b2", 1'b1, 8'hD2, 2'b01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(); drv0(1, 1, 8'hD3, 0); fifo_full = 1'b1; settle();
            expect_out($sformatf("bp.stall%0d", i), 1'b0, 8'h00, 2'b01, 1'b0);
            check($sformatf("bp.stall%0d.ready0", i), 32'(ready0), 32'd0);
        end
        step(); fifo_full = 1'b0; settle();
        expect_out("bp.b3", 1'b1, 8'hD3, 2'b01, 1'b0);
        step(); drv0(1, 1, 8'hD4, 1); settle();
        expect_out("bp.b4", 1'b1, 8'hD4, 2'b01, 1'b0);
        step(); drv0(0, 0, 8'h00, 0); settle();
        expect_out("bp.done", 1'b0, 8'h00, 2'b00, 1'b0);

        // Runaway frame from requester 1, never sets last
        step(); drv1(1, 1, 8'hE1, 0);
        for (int i = 0; i < 4; i++) begin
            step(); drv1(1, 1, 8'hE1 + 8'(i), 0); settle();
            expect_out($sformatf("run.b%0d", i + 1), 1'b1, 8'hE1 + 8'(i), 2'b10, 1'b0);
        end
        step(); drv1(0, 1, 8'hE5, 0); settle();
        expect_out("run.err", 1'b0, 8'h00, 2'b00, 1'b1);
        check("run.err.src", 32'(error_src), 32'd1);
        check("run.err.busy", 32'(busy), 32'd0);
        step(); drv1(0, 1, 8'hE6, 0); settle();
        expect_out("run.after", 1'b0, 8'h00, 2'b00, 1'b0);
        check("run.after.src", 32'(error_src), 32'd1);
        step(); drv1(0, 0, 8'h00, 0);

        // Idle timeout: requester 0 granted but silent, requester 1 waiting
        drv0(1, 0, 8'h00, 0); drv1(1, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            step(); settle();
            expect_out($sformatf("to.own%0d", i + 1), 1'b0, 8'h00, 2'b01, 1'b0);
        end
        step(); settle();
        expect_out("to.err", 1'b0, 8'h00, 2'b00, 1'b1);
        check("to.err.src", 32'(error_src), 32'd0);
        step(); drv0(0, 0, 8'h00, 0); drv1(1, 1, 8'hF1, 1); settle();
        expect_out("to.r1", 1'b1, 8'hF1, 2'b10, 1'b0);
        step(); drv1(0, 0, 8'h00, 0); settle();
        expect_out("to.done", 1'b0, 8'h00, 2'b00, 1'b0);

        // Asynchronous reset in the middle of a frame
        step(); drv0(1, 1, 8'h61, 0);
        step(); settle();
        expect_out("ar.b1", 1'b1, 8'h61, 2'b01, 1'b0);
        step(); drv0(1, 1, 8'h62, 0); settle();
        expect_out("ar.b2", 1'b1, 8'h62, 2'b01, 1'b0);
        #1 reset = 1'b0;
        #1;
        expect_out("ar.inreset", 1'b0, 8'h00, 2'b00, 1'b0);
        check("ar.inreset.busy", 32'(busy), 32'd0);
        check("ar.inreset.ready0", 32'(ready0), 32'd0);
        step(); reset = 1'b1; drv0(0, 0, 8'h00, 0); drv1(1, 1, 8'h71, 1); settle();
        expect_out("ar.idle", 1'b0, 8'h00, 2'b00, 1'b0);
        step(); settle();
        expect_out("ar.r1", 1'b1, 8'h71, 2'b10, 1'b0);
        step(); drv1(0, 0, 8'h00, 0); settle();
        expect_out("ar.done", 1'b0, 8'h00, 2'b00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
